// File: rtl/janela_3x3.sv
// -----------------------------------------------------------------------------
// janela_3x3
//
// Streaming 3x3 window generator feeding the 9-input median sorter.
// Pixels arrive in raster order (one per cycle while pix_valid=1, no
// backpressure). Two line buffers hold the two previous image lines. For every
// pixel whose complete 3x3 neighbourhood is available, the nine neighbourhood
// pixels are presented on w1..w9 in row-major order (w1 top-left, w5 centre,
// w9 bottom-right) and win_valid pulses for one cycle. The centre w5 is
// pixel (r-1, c-1) when pixel (r, c) is accepted.
//
// Parameters
//   LARGURA    image width in pixels (minimum 3)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   pix_valid  pix_in is valid and consumed this cycle
//   sof        start of frame (sampled with pix_valid): pix_in is pixel (0,0)
//   pix_in     8-bit pixel
//   win_valid  one-cycle pulse: w1..w9 hold a new complete window
//   w1..w9     window pixels, row-major
//
// Handshake: a pixel transfers on every rising edge where pix_valid=1; there is
// no ready. win_valid qualifies w1..w9 for exactly one cycle per window and
// w1..w9 hold their values until the next accepted pixel.
//
// Optional build macro
//   JANELA_REG_SAIDA_EN  adds one register stage on w1..w9 and win_valid
//                        (latency 2 cycles after acceptance instead of 1).
// -----------------------------------------------------------------------------
module janela_3x3 #(
   parameter int LARGURA = 640
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_valid,
   input  logic       sof,
   input  logic [7:0] pix_in,
   output logic       win_valid,
   output logic [7:0] w1,
   output logic [7:0] w2,
   output logic [7:0] w3,
   output logic [7:0] w4,
   output logic [7:0] w5,
   output logic [7:0] w6,
   output logic [7:0] w7,
   output logic [7:0] w8,
   output logic [7:0] w9
);

   localparam int             CW          = (LARGURA > 1) ? $clog2(LARGURA) : 1;
   localparam logic [CW-1:0]  COL_MAX     = CW'(LARGURA - 1);
   localparam logic [CW-1:0]  COL_MIN_WIN = CW'(2);
   localparam logic [1:0]     LIN_SAT     = 2'd2;

   // Position counters
   logic [CW-1:0] col_q, col_d;
   logic [1:0]    lin_q, lin_d;

   // Effective position of the pixel on pix_in: sof forces (0,0)
   logic [CW-1:0] col_e;
   logic [1:0]    lin_e;

   // Line buffers: lb0 holds row r-1, lb1 holds row r-2 (no reset, stale data
   // is never exposed thanks to the row gating)
   logic [7:0] lb0_q [LARGURA];
   logic [7:0] lb1_q [LARGURA];
   logic [7:0] lb0_rd, lb1_rd;

   // Window registers, index 0..8 = w1..w9
   logic [7:0] win_q [9];
   logic [7:0] win_d [9];
   logic       win_valid_q, win_valid_d;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      col_e = sof ? '0 : col_q;
      lin_e = sof ? '0 : lin_q;

      // Reads return the contents before this edge's write at the same address
      lb0_rd = lb0_q[col_e];
      lb1_rd = lb1_q[col_e];

      col_d       = col_q;
      lin_d       = lin_q;
      win_d       = win_q;
      win_valid_d = 1'b0;

      if (pix_valid) begin
         // Shift window one column left, new right column enters
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = lb1_rd;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = lb0_rd;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = pix_in;

         // Full neighbourhood exists only from row 2 and column 2 onward
         win_valid_d = (lin_e == LIN_SAT) && (col_e >= COL_MIN_WIN);

         if (col_e == COL_MAX) begin
            col_d = '0;
            lin_d = (lin_e == LIN_SAT) ? LIN_SAT : lin_e + 2'd1;
         end else begin
            col_d = col_e + CW'(1);
            lin_d = lin_e;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Line buffer memories
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb1_q[col_e] <= lb0_rd;
         lb0_q[col_e] <= pix_in;
      end
   end

   // ---------------------------------------------------------------------------
   // Counters and window registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         lin_q       <= '0;
         win_valid_q <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         col_q       <= col_d;
         lin_q       <= lin_d;
         win_valid_q <= win_valid_d;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output stage
   // ---------------------------------------------------------------------------
   logic [7:0] win_out [9];
   logic       win_valid_out;

`ifdef JANELA_REG_SAIDA_EN
   // Extra register to break the path into the combinational sorter. The
   // window registers hold between accepted pixels, so copying every cycle
   // keeps the outputs stable and the valid pulse one cycle wide.
   logic [7:0] out_q [9];
   logic       out_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            out_q[i] <= '0;
         end
      end else begin
         out_valid_q <= win_valid_q;
         for (int i = 0; i < 9; i++) begin
            out_q[i] <= win_q[i];
         end
      end
   end

   assign win_out       = out_q;
   assign win_valid_out = out_valid_q;
`else
   assign win_out       = win_q;
   assign win_valid_out = win_valid_q;
`endif

   assign win_valid = win_valid_out;
   assign w1        = win_out[0];
   assign w2        = win_out[1];
   assign w3        = win_out[2];
   assign w4        = win_out[3];
   assign w5        = win_out[4];
   assign w6        = win_out[5];
   assign w7        = win_out[6];
   assign w8        = win_out[7];
   assign w9        = win_out[8];

endmodule

// File: tb/tb_janela_3x3.sv
// -----------------------------------------------------------------------------
// tb_janela_3x3: self-checking bench for janela_3x3 with LARGURA=4.
// Expected windows are queued with the cycle they must appear in; a monitor
// compares every cycle (window match when due, win_valid=0 otherwise).
// -----------------------------------------------------------------------------
module tb_janela_3x3;

  localparam int W = 4;
`ifdef JANELA_REG_SAIDA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] pix_in = '0;
  logic       win_valid;
  logic [7:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;

  janela_3x3 #(.LARGURA(W)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .sof(sof), .pix_in(pix_in),
    .win_valid(win_valid),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [103:0] exp_q[$];   // {due cycle[31:0], window[71:0]}
  int checks = 0;
  int fails = 0;
  int pulses = 0;
  logic mon_en = 1'b0;

  function automatic logic [71:0] got_win();
    return {w1, w2, w3, w4, w5, w6, w7, w8, w9};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [103:0] e;
      if (win_valid) pulses++;
      checks++;
      if (exp_q.size() > 0 && exp_q[0][103:72] == 32'(cyc)) begin
        e = exp_q.pop_front();
        if (win_valid !== 1'b1 || got_win() !== e[71:0]) begin
          fails++;
          $display("FAIL window cyc=%0d: valid=%b got=%h expected valid=1 %h",
                   cyc, win_valid, got_win(), e[71:0]);
        end
      end else if (win_valid !== 1'b0) begin
        fails++;
        $display("FAIL spurious_valid cyc=%0d: valid=%b got=%h expected valid=0",
                 cyc, win_valid, got_win());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic has_win(input int idx);
    return ((idx / W) >= 2) && ((idx % W) >= 2);
  endfunction

  // Window for ramp pixel idx (value base+idx), row-major, w1 at MSB
  function automatic logic [71:0] win_of(input int base, input int idx);
    logic [71:0] r;
    int rr, cc;
    rr = idx / W;
    cc = idx % W;
    r = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        r = {r[63:0], 8'(base + (rr - 2 + dr) * W + (cc - 2 + dc))};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] p, input logic s, input logic ew, input logic [71:0] w);
    @(negedge clk);
    pix_valid = 1'b1;
    sof = s;
    pix_in = p;
    if (ew) exp_q.push_back({32'(cyc + LAT), w});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      sof = 1'($urandom_range(0, 1));   // sof must be ignored without pix_valid
      pix_in = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic ramp(input int base, input logic use_sof, input logic gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps && ((i % W) == 0 || $urandom_range(0, 1) == 1) && i != 0)
        idle($urandom_range(1, 5));
      send(8'(base + i), use_sof && (i == 0), has_win(i), win_of(base, i));
    end
  endtask

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic end_scenario(input string name, input int exp_pulses);
    idle(LAT + 3);
    check({name, "_pulses"}, 72'(pulses), 72'(exp_pulses));
    check({name, "_drained"}, 72'(exp_q.size()), 72'd0);
    pulses = 0;
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_valid"}, 72'(win_valid), 72'd0);
    check({name, "_win"}, got_win(), 72'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  pix;
    logic        sof;
    logic        exp_win;
    logic [71:0] exp_w;
  } vec_t;
  vec_t tbl[16];

  // ---------------- main ----------------
  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].pix = 8'(i);
      tbl[i].sof = (i == 0);
      tbl[i].exp_win = 1'b0;
      tbl[i].exp_w = '0;
    end
    tbl[10].exp_win = 1'b1; tbl[10].exp_w = 72'h00_01_02_04_05_06_08_09_0A;
    tbl[11].exp_win = 1'b1; tbl[11].exp_w = 72'h01_02_03_05_06_07_09_0A_0B;
    tbl[14].exp_win = 1'b1; tbl[14].exp_w = 72'h04_05_06_08_09_0A_0C_0D_0E;
    tbl[15].exp_win = 1'b1; tbl[15].exp_w = 72'h05_06_07_09_0A_0B_0D_0E_0F;

    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Scenario 1: continuous ramp from the table (also covers line-wrap gating)
    for (int i = 0; i < 16; i++)
      send(tbl[i].pix, tbl[i].sof, tbl[i].exp_win, tbl[i].exp_w);
    end_scenario("ramp", 4);

    // Scenario 2: same ramp with random gaps, always a gap at line wraps
    ramp(0, 1'b1, 1'b1, 16);
    end_scenario("ramp_gaps", 4);

    // Scenario 3: abort after pixel 9 with a fresh sof frame
    ramp(0, 1'b1, 1'b0, 10);
    ramp(100, 1'b1, 1'b0, 16);
    end_scenario("mid_sof", 4);

    // Scenario 4: asynchronous reset between edges after pixel 11
    ramp(0, 1'b1, 1'b0, 12);
    @(posedge clk);
    #1;
    check("pre_reset_valid", 72'(win_valid), 72'd1);
    check("pre_reset_win", got_win(), win_of(0, (LAT == 1) ? 11 : 10));
    exp_q.delete();
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    repeat (2) @(negedge clk);
    check_reset_state("held_reset");
    rst_n = 1'b1;
    pulses = 0;
    // First pixel after reset is (0,0) without sof
    ramp(0, 1'b0, 1'b0, 16);
    end_scenario("post_reset", 4);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/janela_3x3.md
# janela_3x3

Streaming 3x3 window generator that sits directly upstream of the 9-input sorter in the median filter path. It accepts 8-bit pixels in raster order, one per accepted cycle, and keeps the two previous image lines in internal line buffers. For every pixel whose full 3x3 neighbourhood exists, it presents the nine neighbourhood pixels in sorter input order (n1_n..n9_n). The sorter output n5 is then the median for centre pixel w5.

## Interface
- LARGURA, default 640: image width in pixels, minimum 3.
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- pix_valid, input, 1: pix_in is valid this cycle; no backpressure, so every valid cycle is consumed.
- sof, input, 1: start of frame, sampled only when pix_valid=1; marks pix_in as pixel (0,0).
- pix_in, input, 8: pixel value.
- win_valid, output, 1: w1..w9 hold a new complete window; pulses for one cycle per window.
- w1..w9, output, 8 each: window in row-major order (w1 top-left, w5 centre, w9 bottom-right), wired directly to n1_n..n9_n.

## Operation
- Counters:
  - col: $clog2(LARGURA) bits, range 0..LARGURA-1.
  - lin: 2 bits, saturates at 2; only "row ≥ 2" matters.
- Accepted pixel at (lin, col), i.e. pix_valid=1:
  - Window columns shift left: w1<=w2, w2<=w3, w4<=w5, w5<=w6, w7<=w8, w8<=w9.
  - New right column: w3<=lb1[col] (row r-2), w6<=lb0[col] (row r-1), w9<=pix_in (row r).
  - Line buffers update: lb1[col]<=lb0[col], lb0[col]<=pix_in.
  - Read and write at the same address happen on the same edge; the read returns the old contents.
  - col increments. At col=LARGURA-1 it wraps to 0 and lin increments (saturating).
- win_valid<=1 when an accepted pixel has lin=2 and col≥2, otherwise 0. The window centre is then pixel (r-1, c-1).
- No window is emitted for the first two rows of a frame, or for columns 0 and 1 of any row. Border pixels are not filtered.
- sof with pix_valid: the current pixel is treated as (0,0).
  - After this pixel, col=1 and lin=0.
  - Valid even mid-frame: it aborts the frame in progress and emits no window for that pixel.
- Line buffers are not cleared by sof or reset. Stale contents are never used in an emitted window because of the row gating.
- pix_valid=0: all state holds and win_valid<=0. Stall gaps of any length are allowed anywhere, including across line wraps.
- Line buffers: two arrays of LARGURA x 8 bits, inferred as memory, no reset.

## Timing
- Reset (rst_n=0, asynchronous): col=0, lin=0, win_valid=0, w1..w9=0.
- After reset, the first accepted pixel is (0,0) even without sof.
- Latency: the window containing pixel (r,c) is on w1..w9 with win_valid=1 in the cycle after the edge that accepts it.
- Outputs hold their values until the next accepted pixel.
- Throughput: one window per clock at sustained pix_valid=1.
- Reset mid-frame takes effect immediately: win_valid drops to 0 in the same cycle.

## Configuration
- JANELA_REG_SAIDA_EN defined:
  - Adds one output register stage on w1..w9 and win_valid, all reset to 0.
  - Latency becomes 2 cycles after acceptance, to ease timing into the combinational sorter.
  - win_valid still pulses one cycle per window.
- JANELA_REG_SAIDA_EN undefined: 1-cycle latency as described above.

## Test plan
- Ramp, LARGURA=4, pixels 0..15 continuous, sof on pixel 0:
  - Exactly 4 win_valid pulses.
  - First pulse the cycle after pixel 10, with w1..w9 = 0,1,2,4,5,6,8,9,10.
  - Last pulse with 5,6,7,9,10,11,13,14,15.
- Same ramp with random pix_valid gaps (1–5 cycles), including gaps at line wraps: identical 4 windows in identical order, and win_valid=0 during gaps.
- Line-wrap gating, LARGURA=4: no win_valid after pixels 8, 9, 12 or 13; pulses after pixels 10, 11, 14, 15.
- Mid-frame sof after pixel 9, then a fresh ramp 100..115:
  - No window until new pixel 110.
  - The window after 110 is 100,101,102,104,105,106,108,109,110, with no stale data from the aborted frame.
- Async reset asserted after pixel 11 with no clock edge:
  - win_valid and w1..w9 go to 0 immediately.
  - After release, the next frame behaves as in the first scenario.
- JANELA_REG_SAIDA_EN defined: first scenario's windows appear 2 cycles after acceptance, with identical values and pulse count.
